// File: rtl/four_bank_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// four_bank_mem_ctrl_pkg
//   Constants for the four-bank interleaved main memory.
//   Memory word width, bank-select field position, bank occupancy time and
//   read latency live here so the top and the bank sub-module agree.
// ---------------------------------------------------------------------------
package four_bank_mem_ctrl_pkg;

   localparam int WORD_W    = 16;  // memory word width
   localparam int NUM_BANKS = 4;
   localparam int BANK_W    = 2;   // width of the bank-select field
   localparam int BANK_LSB  = 1;   // bank = addr[BANK_LSB+BANK_W-1:BANK_LSB] = addr[2:1]
   localparam int ROW_LSB   = 3;   // row  = addr[ADDR_W-1:3]
   localparam int BANK_OCC  = 4;   // cycles a bank is busy per access, incl. accept cycle
   localparam int RD_LAT    = 2;   // accept-to-data latency; the bank pipeline is built for 2
   localparam int CNT_W     = 2;   // occupancy counter width, holds BANK_OCC-1

   // Value loaded into a bank's occupancy counter on accept.
   localparam logic [CNT_W-1:0] OCC_LOAD = CNT_W'(BANK_OCC - 1);

endpackage : four_bank_mem_ctrl_pkg

// File: rtl/four_bank_mem_ctrl_mem_bank.sv
// ---------------------------------------------------------------------------
// mem_bank
//   One bank of the interleaved memory: single-port word array, occupancy
//   down-counter with busy flag, and a RD_LAT-deep read pipeline.
//
// Ports
//   clk      in   1       system clock, rising edge
//   rst_n    in   1       asynchronous active-low reset
//   i_acc    in   1       request accepted for this bank this cycle
//   i_we     in   1       accepted request is a write (else a read)
//   i_row    in   ROW_W   word index within the bank
//   i_data   in   WORD_W  write data
//   o_busy   out  1       bank occupied, refuses new requests
//   o_data   out  WORD_W  read data from the last pipeline stage, 0 when invalid
// ---------------------------------------------------------------------------
module mem_bank
   import four_bank_mem_ctrl_pkg::*;
#(
   parameter int ROW_W = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_acc,
   input  logic              i_we,
   input  logic [ROW_W-1:0]  i_row,
   input  logic [WORD_W-1:0] i_data,
   output logic              o_busy,
   output logic [WORD_W-1:0] o_data
);

   // Array contents are deliberately not reset.
   logic [WORD_W-1:0] r_mem [2**ROW_W];

   logic [CNT_W-1:0]  r_cnt;
   logic [RD_LAT-1:0] r_vld;      // r_vld[0]: stage 1 (row captured), r_vld[1]: stage 2 (data)
   logic [ROW_W-1:0]  r_s1_row;
   logic [WORD_W-1:0] r_s2_data;

   // Write commits at the accept edge, so any read accepted later sees it.
   always_ff @(posedge clk) begin
      if (i_acc && i_we) begin
         r_mem[i_row] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_vld     <= '0;
         r_s1_row  <= '0;
         r_s2_data <= '0;
      end else begin
         // Accept only happens with the counter at zero, so load and
         // count-down never collide.
         if (i_acc) begin
            r_cnt <= OCC_LOAD;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end

         r_vld <= {r_vld[RD_LAT-2:0], i_acc & ~i_we};

         if (i_acc) begin
            r_s1_row <= i_row;
         end

         // The bank is still busy while its read is in flight, so no write
         // can land between capture of the row and the array read.
         if (r_vld[0]) begin
            r_s2_data <= r_mem[r_s1_row];
         end
      end
   end

   assign o_busy = (r_cnt != '0);
   assign o_data = r_vld[RD_LAT-1] ? r_s2_data : '0;

endmodule : mem_bank

// File: rtl/four_bank_mem_ctrl.sv
// ---------------------------------------------------------------------------
// four_bank_mem_ctrl
//   Four-bank interleaved main memory below the cache controller FSM.
//   One request per cycle; bank = addr[2:1]. A bank stays busy for BANK_OCC
//   cycles after accepting, read data appears RD_LAT cycles after accept.
//
// Ports
//   clk       in   1       system clock, rising edge
//   rst_n     in   1       asynchronous active-low reset
//   addr      in   ADDR_W  byte address (bank = addr[2:1], row = addr[ADDR_W-1:3])
//   data_in   in   16      write data
//   wr        in   1       write request
//   rd        in   1       read request
//   data_out  out  16      read data for one cycle at accept+2, else 0
//   busy      out  4       per-bank occupancy
//   err       out  1       wr&rd together, or a request with addr[0]=1
//
// Handshake: a request is accepted in the cycle where exactly one of wr/rd is
// high, addr is word aligned and the target bank's busy bit is low. Otherwise
// it is ignored and the requester keeps it asserted until accepted.
// ---------------------------------------------------------------------------
module four_bank_mem_ctrl
   import four_bank_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] data_in,
   input  logic              wr,
   input  logic              rd,
   output logic [WORD_W-1:0] data_out,
   output logic [3:0]        busy,
   output logic              err
);

   localparam int ROW_W = ADDR_W - ROW_LSB;

   logic [BANK_W-1:0]           w_bank;
   logic [ROW_W-1:0]            w_row;
   logic                        w_acc;
   logic [NUM_BANKS-1:0]        w_bank_acc;
   logic [NUM_BANKS-1:0]        w_busy;
   logic [WORD_W-1:0]           w_bank_data [NUM_BANKS];

   assign w_bank = addr[BANK_LSB +: BANK_W];
   assign w_row  = addr[ADDR_W-1:ROW_LSB];

   // wr^rd is false when both are high, so an errored request never accepts.
   assign w_acc = (wr ^ rd) & ~addr[0] & ~w_busy[w_bank];
   assign err   = (wr & rd) | ((wr | rd) & addr[0]);

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign w_bank_acc[b] = w_acc & (w_bank == BANK_W'(b));

      mem_bank #(
         .ROW_W (ROW_W)
      ) u_bank (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_acc  (w_bank_acc[b]),
         .i_we   (wr),
         .i_row  (w_row),
         .i_data (data_in),
         .o_busy (w_busy[b]),
         .o_data (w_bank_data[b])
      );
   end

   // At most one bank has a valid stage-2 word in any cycle (one accept per
   // cycle), and idle banks drive 0, so an OR is a correct one-hot mux.
   always_comb begin
      data_out = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         data_out = data_out | w_bank_data[b];
      end
   end

   assign busy = w_busy;

endmodule : four_bank_mem_ctrl

// File: tb/tb_four_bank_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_four_bank_mem_ctrl
//   Directed bench for four_bank_mem_ctrl. Inputs change 1 time unit after a
//   rising edge (that is the start of "cycle T"); outputs are sampled on the
//   falling edge inside the same cycle.
// ---------------------------------------------------------------------------
module tb_four_bank_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        wr;
   logic        rd;
   logic [15:0] data_out;
   logic [3:0]  busy;
   logic        err;

   int n_checks;
   int n_errors;

   logic [15:0] exp_q[$];

   four_bank_mem_ctrl #(
      .ADDR_W (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .data_in  (data_in),
      .wr       (wr),
      .rd       (rd),
      .data_out (data_out),
      .busy     (busy),
      .err      (err)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
      wr      = w;
      rd      = r;
      addr    = a;
      data_in = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   // Check outputs for the current cycle, then advance to the next cycle.
   task automatic cyc(input string tag, input logic [3:0] eb, input logic [15:0] ed, input logic ee);
      @(negedge clk);
      check({tag, ".busy"}, {12'h0, busy}, {12'h0, eb});
      check({tag, ".data"}, data_out, ed);
      check({tag, ".err"},  {15'h0, err},  {15'h0, ee});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      idle();
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;

      // 1. Reset held 3 cycles with a read pending on the inputs.
      drive(1'b0, 1'b1, 16'h0000, 16'h0000);
      #1;
      cyc("rst0", 4'b0000, 16'h0000, 1'b0);
      cyc("rst1", 4'b0000, 16'h0000, 1'b0);
      cyc("rst2", 4'b0000, 16'h0000, 1'b0);
      idle();
      rst_n = 1'b1;
      cyc("rst_rel", 4'b0000, 16'h0000, 1'b0);

      // 2. Write BEEF to 0x0012 (bank1), then read it back.
      drive(1'b1, 1'b0, 16'h0012, 16'hBEEF);
      cyc("wr_T",    4'b0000, 16'h0000, 1'b0);
      idle();
      cyc("wr_T1",   4'b0010, 16'h0000, 1'b0);
      cyc("wr_T2",   4'b0010, 16'h0000, 1'b0);
      cyc("wr_T3",   4'b0010, 16'h0000, 1'b0);
      drive(1'b0, 1'b1, 16'h0012, 16'h0000);
      cyc("rd_T4",   4'b0000, 16'h0000, 1'b0);
      idle();
      cyc("rd_T5",   4'b0010, 16'h0000, 1'b0);
      cyc("rd_T6",   4'b0010, 16'hBEEF, 1'b0);
      cyc("rd_T7",   4'b0010, 16'h0000, 1'b0);
      cyc("rd_T8",   4'b0000, 16'h0000, 1'b0);

      // 3. Line fill: four writes, settle, four back-to-back reads.
      drive(1'b1, 1'b0, 16'h0100, 16'h1111);
      cyc("lw0", 4'b0000, 16'h0000, 1'b0);
      drive(1'b1, 1'b0, 16'h0102, 16'h2222);
      cyc("lw1", 4'b0001, 16'h0000, 1'b0);
      drive(1'b1, 1'b0, 16'h0104, 16'h3333);
      cyc("lw2", 4'b0011, 16'h0000, 1'b0);
      drive(1'b1, 1'b0, 16'h0106, 16'h4444);
      cyc("lw3", 4'b0111, 16'h0000, 1'b0);
      idle();
      cyc("lw4", 4'b1110, 16'h0000, 1'b0);
      cyc("lw5", 4'b1100, 16'h0000, 1'b0);
      cyc("lw6", 4'b1000, 16'h0000, 1'b0);
      cyc("lw7", 4'b0000, 16'h0000, 1'b0);

      exp_q.push_back(16'h1111);
      exp_q.push_back(16'h2222);
      exp_q.push_back(16'h3333);
      exp_q.push_back(16'h4444);
      drive(1'b0, 1'b1, 16'h0100, 16'h0000);
      cyc("lr0", 4'b0000, 16'h0000, 1'b0);
      drive(1'b0, 1'b1, 16'h0102, 16'h0000);
      cyc("lr1", 4'b0001, 16'h0000, 1'b0);
      drive(1'b0, 1'b1, 16'h0104, 16'h0000);
      cyc("lr2", 4'b0011, exp_q.pop_front(), 1'b0);
      drive(1'b0, 1'b1, 16'h0106, 16'h0000);
      cyc("lr3", 4'b0111, exp_q.pop_front(), 1'b0);
      idle();
      cyc("lr4", 4'b1110, exp_q.pop_front(), 1'b0);
      cyc("lr5", 4'b1100, exp_q.pop_front(), 1'b0);
      cyc("lr6", 4'b1000, 16'h0000, 1'b0);
      cyc("lr7", 4'b0000, 16'h0000, 1'b0);

      // 4. Bank conflict on bank0: 0x0000 then 0x0008.
      drive(1'b1, 1'b0, 16'h0000, 16'hA0A0);
      cyc("cw0", 4'b0000, 16'h0000, 1'b0);
      idle_cycles(3);
      drive(1'b1, 1'b0, 16'h0008, 16'hB0B0);
      cyc("cw1", 4'b0000, 16'h0000, 1'b0);
      idle_cycles(3);
      drive(1'b0, 1'b1, 16'h0000, 16'h0000);
      cyc("cf_T",  4'b0000, 16'h0000, 1'b0);
      drive(1'b0, 1'b1, 16'h0008, 16'h0000);
      cyc("cf_T1", 4'b0001, 16'h0000, 1'b0);
      cyc("cf_T2", 4'b0001, 16'hA0A0, 1'b0);
      cyc("cf_T3", 4'b0001, 16'h0000, 1'b0);
      cyc("cf_T4", 4'b0000, 16'h0000, 1'b0);
      idle();
      cyc("cf_T5", 4'b0001, 16'h0000, 1'b0);
      cyc("cf_T6", 4'b0001, 16'hB0B0, 1'b0);
      cyc("cf_T7", 4'b0001, 16'h0000, 1'b0);
      cyc("cf_T8", 4'b0000, 16'h0000, 1'b0);

      // 5. Error requests are flagged and never accepted.
      drive(1'b1, 1'b1, 16'h0000, 16'h5555);
      cyc("e_wrrd",  4'b0000, 16'h0000, 1'b1);
      idle();
      cyc("e_wrrd1", 4'b0000, 16'h0000, 1'b0);
      drive(1'b0, 1'b1, 16'h0003, 16'h0000);
      cyc("e_odd",   4'b0000, 16'h0000, 1'b1);
      idle();
      cyc("e_odd1",  4'b0000, 16'h0000, 1'b0);
      cyc("e_odd2",  4'b0000, 16'h0000, 1'b0);
      cyc("e_odd3",  4'b0000, 16'h0000, 1'b0);
      // The refused write must not have overwritten address 0x0000.
      drive(1'b0, 1'b1, 16'h0000, 16'h0000);
      cyc("e_chk0", 4'b0000, 16'h0000, 1'b0);
      idle();
      cyc("e_chk1", 4'b0001, 16'h0000, 1'b0);
      cyc("e_chk2", 4'b0001, 16'hA0A0, 1'b0);
      idle_cycles(2);

      // 6. Reset while a read of 0x0012 is in flight.
      drive(1'b0, 1'b1, 16'h0012, 16'h0000);
      cyc("rm_T", 4'b0000, 16'h0000, 1'b0);
      idle();
      rst_n = 1'b0;
      cyc("rm_T1", 4'b0000, 16'h0000, 1'b0);
      cyc("rm_T2", 4'b0000, 16'h0000, 1'b0);
      rst_n = 1'b1;
      cyc("rm_T3", 4'b0000, 16'h0000, 1'b0);
      cyc("rm_T4", 4'b0000, 16'h0000, 1'b0);
      drive(1'b0, 1'b1, 16'h0012, 16'h0000);
      cyc("rr_T",  4'b0000, 16'h0000, 1'b0);
      idle();
      cyc("rr_T1", 4'b0010, 16'h0000, 1'b0);
      cyc("rr_T2", 4'b0010, 16'hBEEF, 1'b0);
      cyc("rr_T3", 4'b0010, 16'h0000, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_four_bank_mem_ctrl
